// File: rtl/segment_scan_pkg.sv
// Shared types and constants for the segment scan driver and its hex decoder.
package segment_scan_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} patterns for nibbles 0..F
    localparam logic [6:0] HEX_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble to active-low 7-segment pattern.
module seg_hex_decoder
    import segment_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = HEX_LUT[nibble];
    end

endmodule

// File: rtl/segment_scan_driver.sv
// Eight-digit multiplexed 7-segment scanner with slot blanking, PWM dimming
// and frame-atomic shadow registers.
module segment_scan_driver
    import segment_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [31:0] digit_data,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp_mask,
    input  logic [3:0]  brightness,
    input  logic        update,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [7:0]  an_n,
    output logic        frame_done
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    // Reset synchroniser: assertion is immediate, release lines up with ACLK
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    always_comb begin
        rst_n = rst_sync_q[1];
    end

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       pwm_cnt_q, pwm_cnt_d;
    scan_state_t      state_q, state_d;
    logic             pending_q, pending_d;

    logic [31:0]      data_sh_q, data_sh_d;
    logic [7:0]       en_sh_q, en_sh_d;
    logic [7:0]       dp_sh_q, dp_sh_d;
    logic [3:0]       bright_sh_q, bright_sh_d;

    logic [7:0]       an_n_q, an_n_d;
    logic [6:0]       seg_n_q, seg_n_d;
    logic             dp_n_q, dp_n_d;
    logic             frame_done_q, frame_done_d;

    logic             slot_wrap;
    logic             frame_boundary;
    logic             load_shadow;
    logic             drive;
    logic [3:0]       sel_nibble;
    logic [6:0]       dec_seg_n;

    always_comb begin
        slot_wrap      = (div_cnt_q == DIV_LAST);
        frame_boundary = slot_wrap && (idx_q == IDX_LAST);
        load_shadow    = frame_boundary && (pending_q || update);
    end

    always_comb begin
        div_cnt_d = slot_wrap ? '0 : div_cnt_q + DIV_W'(1);
        idx_d     = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        pwm_cnt_d = pwm_cnt_q + 4'd1;
    end

    // An update on the boundary cycle itself is taken directly, so pending
    // only needs to remember requests from earlier in the frame.
    always_comb begin
        pending_d   = load_shadow ? 1'b0 : (pending_q || update);
        data_sh_d   = data_sh_q;
        en_sh_d     = en_sh_q;
        dp_sh_d     = dp_sh_q;
        bright_sh_d = bright_sh_q;
        if (load_shadow) begin
            data_sh_d   = digit_data;
            en_sh_d     = digit_enable_mask();
            dp_sh_d     = dp_mask;
            bright_sh_d = brightness;
        end
    end

    function automatic logic [7:0] digit_enable_mask();
        return digit_en;
    endfunction

    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BLANK: if (div_cnt_q == BLANK_LAST) state_d = ON;
            ON:    if (slot_wrap)               state_d = BLANK;
            default:                            state_d = BLANK;
        endcase
    end

    always_comb begin
        sel_nibble = data_sh_q[{idx_q, 2'b00} +: 4];
    end

    seg_hex_decoder u_hex_decoder (
        .nibble (sel_nibble),
        .seg_n  (dec_seg_n)
    );

    always_comb begin
        drive        = (state_q == ON) && en_sh_q[idx_q] && (pwm_cnt_q <= bright_sh_q);
        an_n_d       = AN_OFF;
        seg_n_d      = SEG_OFF;
        dp_n_d       = 1'b1;
        frame_done_d = frame_boundary;
        if (drive) begin
            an_n_d  = ~(8'(1) << idx_q);
            seg_n_d = dec_seg_n;
            dp_n_d  = ~dp_sh_q[idx_q];
        end
    end

    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            pwm_cnt_q    <= '0;
            pending_q    <= 1'b0;
            data_sh_q    <= '0;
            en_sh_q      <= '0;
            dp_sh_q      <= '0;
            bright_sh_q  <= '0;
            an_n_q       <= AN_OFF;
            seg_n_q      <= SEG_OFF;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            pwm_cnt_q    <= pwm_cnt_d;
            pending_q    <= pending_d;
            data_sh_q    <= data_sh_d;
            en_sh_q      <= en_sh_d;
            dp_sh_q      <= dp_sh_d;
            bright_sh_q  <= bright_sh_d;
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        an_n       = an_n_q;
        seg_n      = seg_n_q;
        dp_n       = dp_n_q;
        frame_done = frame_done_q;
    end

endmodule

// File: tb/tb_segment_scan_driver.sv
// Directed, table-driven bench for segment_scan_driver at SCAN_DIV=32, BLANK_CYCLES=4.
module tb_segment_scan_driver;

    localparam int SD = 32;
    localparam int BC = 4;
    localparam logic [15:0] OFF = {8'hFF, 7'h7F, 1'b1};

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b1;
    logic [31:0] digit_data = '0;
    logic [7:0]  digit_en = '0;
    logic [7:0]  dp_mask = '0;
    logic [3:0]  brightness = '0;
    logic        update = 1'b0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [7:0]  an_n;
    logic        frame_done;

    int n_vec = 0;
    int n_bad = 0;
    int pos = 0;

    always #5 ACLK = ~ACLK;

    segment_scan_driver #(
        .NUM_DIGITS   (8),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .digit_data (digit_data),
        .digit_en   (digit_en),
        .dp_mask    (dp_mask),
        .brightness (brightness),
        .update     (update),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [31:0] data;
        logic [7:0]  en;
        logic [7:0]  dp;
        logic [3:0]  bright;
        int          k;
        int          c;
        logic [7:0]  exp_an;
        logic [6:0]  exp_seg;
        logic        exp_dp;
    } vec_t;

    vec_t vt [15];

    function automatic logic [15:0] outs();
        return {an_n, seg_n, dp_n};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
            pos++;
        end
    endtask

    // pos 0 is the sample where frame_done is high; sample 1+k*SD+c shows slot k, count c
    task automatic wait_frame();
        bit found;
        found = 1'b0;
        for (int t = 0; t < 600; t++) begin
            @(posedge ACLK);
            #1;
            if (frame_done) begin
                found = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!found) begin
            n_bad++;
            $display("FAIL frame_timeout: got no frame_done expected pulse within 600 cycles");
        end
        pos = 0;
    endtask

    task automatic go_to(input int k, input int c);
        int tgt;
        tgt = 1 + k * SD + c;
        if (tgt <= pos) wait_frame();
        step(tgt - pos);
    endtask

    task automatic load(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p, input logic [3:0] b);
        digit_data = d;
        digit_en   = e;
        dp_mask    = p;
        brightness = b;
        update     = 1'b1;
        step(1);
        update     = 1'b0;
        wait_frame();
    endtask

    initial begin
        int act;
        bit have_cfg;
        logic [31:0] cd;
        logic [7:0]  ce, cp;
        logic [3:0]  cb;
        int expc [3];
        logic [3:0] bl [3];

        vt[0]  = '{32'h76543210, 8'hFF, 8'h00, 4'hF, 0,  3, 8'hFF, 7'h7F, 1'b1};
        vt[1]  = '{32'h76543210, 8'hFF, 8'h00, 4'hF, 0,  4, 8'hFE, 7'h40, 1'b1};
        vt[2]  = '{32'h76543210, 8'hFF, 8'h00, 4'hF, 1, 10, 8'hFD, 7'h79, 1'b1};
        vt[3]  = '{32'h76543210, 8'hFF, 8'h00, 4'hF, 2, 10, 8'hFB, 7'h24, 1'b1};
        vt[4]  = '{32'h76543210, 8'hFF, 8'h00, 4'hF, 3,  0, 8'hFF, 7'h7F, 1'b1};
        vt[5]  = '{32'h76543210, 8'hFF, 8'h00, 4'hF, 3, 10, 8'hF7, 7'h30, 1'b1};
        vt[6]  = '{32'h76543210, 8'hFF, 8'h00, 4'hF, 4, 10, 8'hEF, 7'h19, 1'b1};
        vt[7]  = '{32'h76543210, 8'hFF, 8'h00, 4'hF, 5, 10, 8'hDF, 7'h12, 1'b1};
        vt[8]  = '{32'h76543210, 8'hFF, 8'h00, 4'hF, 6, 10, 8'hBF, 7'h02, 1'b1};
        vt[9]  = '{32'h76543210, 8'hFF, 8'h00, 4'hF, 7, 31, 8'h7F, 7'h78, 1'b1};
        vt[10] = '{32'hFEDCBA98, 8'h05, 8'h04, 4'hF, 0,  5, 8'hFE, 7'h00, 1'b1};
        vt[11] = '{32'hFEDCBA98, 8'h05, 8'h04, 4'hF, 1,  5, 8'hFF, 7'h7F, 1'b1};
        vt[12] = '{32'hFEDCBA98, 8'h05, 8'h04, 4'hF, 2, 20, 8'hFB, 7'h08, 1'b0};
        vt[13] = '{32'hFEDCBA98, 8'h05, 8'h04, 4'hF, 3, 20, 8'hFF, 7'h7F, 1'b1};
        vt[14] = '{32'hFEDCBA98, 8'h05, 8'h04, 4'hF, 7, 31, 8'hFF, 7'h7F, 1'b1};

        // Reset and idle: enables present on the inputs but never loaded
        #2 ARESETN = 1'b0;
        repeat (20) @(posedge ACLK);
        #1;
        check("reset_outs", outs(), OFF);
        check("reset_frame_done", {15'b0, frame_done}, 16'd0);
        digit_data = 32'h76543210;
        digit_en   = 8'hFF;
        brightness = 4'hF;
        #3 ARESETN = 1'b1;
        act = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (an_n != 8'hFF) act++;
        end
        check("idle_no_anode", 16'(act), 16'd0);

        have_cfg = 1'b0;
        cd = '0; ce = '0; cp = '0; cb = '0;
        for (int i = 0; i < 15; i++) begin
            if (!have_cfg || vt[i].data != cd || vt[i].en != ce || vt[i].dp != cp || vt[i].bright != cb) begin
                cd = vt[i].data; ce = vt[i].en; cp = vt[i].dp; cb = vt[i].bright;
                have_cfg = 1'b1;
                load(cd, ce, cp, cb);
            end
            go_to(vt[i].k, vt[i].c);
            check($sformatf("vec%0d_k%0d_c%0d", i, vt[i].k, vt[i].c), outs(),
                  {vt[i].exp_an, vt[i].exp_seg, vt[i].exp_dp});
        end

        // frame_done period
        wait_frame();
        step(255);
        check("fd_before", {15'b0, frame_done}, 16'd0);
        step(1);
        check("fd_at_256", {15'b0, frame_done}, 16'd1);
        step(1);
        check("fd_after", {15'b0, frame_done}, 16'd0);

        // PWM duty over 16 consecutive ON cycles of digit 0
        bl[0] = 4'd0;  expc[0] = 1;
        bl[1] = 4'd7;  expc[1] = 8;
        bl[2] = 4'd15; expc[2] = 16;
        for (int j = 0; j < 3; j++) begin
            load(32'h0, 8'h01, 8'h00, bl[j]);
            go_to(0, 4);
            act = 0;
            for (int i = 0; i < 16; i++) begin
                if (an_n == 8'hFE) act++;
                step(1);
            end
            check($sformatf("pwm_b%0d", bl[j]), 16'(act), 16'(expc[j]));
        end

        // Mid-frame update stays out of the current frame
        load(32'h76543210, 8'hFF, 8'h00, 4'hF);
        go_to(3, 10);
        digit_data = 32'hFEDCBA98;
        update = 1'b1;
        step(1);
        update = 1'b0;
        go_to(4, 10); check("atomic_d4", outs(), {8'hEF, 7'h19, 1'b1});
        go_to(5, 10); check("atomic_d5", outs(), {8'hDF, 7'h12, 1'b1});
        go_to(6, 10); check("atomic_d6", outs(), {8'hBF, 7'h02, 1'b1});
        go_to(7, 10); check("atomic_d7", outs(), {8'h7F, 7'h78, 1'b1});
        go_to(0, 10); check("atomic_new_d0", outs(), {8'hFE, 7'h00, 1'b1});
        go_to(1, 10); check("atomic_new_d1", outs(), {8'hFD, 7'h10, 1'b1});

        // Update pulse exactly on the boundary cycle
        go_to(7, 30); check("bnd_old_d7", outs(), {8'h7F, 7'h0E, 1'b1});
        digit_data = 32'h00000005;
        update = 1'b1;
        step(1);
        update = 1'b0;
        check("bnd_frame_done", {15'b0, frame_done}, 16'd1);
        pos = 0;
        go_to(0, 10); check("bnd_new_d0", outs(), {8'hFE, 7'h12, 1'b1});
        go_to(1, 10); check("bnd_new_d1", outs(), {8'hFD, 7'h40, 1'b1});

        // Asynchronous reset in the middle of digit 5's ON time
        go_to(5, 10); check("pre_rst_d5", outs(), {8'hDF, 7'h40, 1'b1});
        #2 ARESETN = 1'b0;
        #1;
        check("async_rst_outs", outs(), OFF);
        check("async_rst_fd", {15'b0, frame_done}, 16'd0);
        repeat (5) @(posedge ACLK);
        #3 ARESETN = 1'b1;
        act = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (an_n != 8'hFF) act++;
        end
        check("post_rst_dark", 16'(act), 16'd0);
        load(32'h00000005, 8'hFF, 8'h00, 4'hF);
        go_to(0, 10); check("post_rst_reload", outs(), {8'hFE, 7'h12, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
